logic_mux2_capture: RTL and testbench



---
 rtl/logic_mux2_capture_pkg.sv | 39 +++
 rtl/logic_mux2_capture_if.sv | 40 ++++
 rtl/logic_mux2_capture_sync_filter.sv | 111 +++++++++++
 rtl/logic_mux2_capture.sv | 126 ++++++++++++
 tb/tb_logic_mux2_capture.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/logic_mux2_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module   : logic_mux2_capture_pkg
// Purpose  : Shared types, constants and helpers for the mux-output capture
//            block (filter FSM states, event record, width saturation).
// Options  : LOGIC_MUX2_CAPTURE_WIDTH_EN adds the held-level width field.
// Revision : 1.0 - initial release
// ============================================================================
package logic_mux2_capture_pkg;

  // Widest transition count an event record can carry.
  localparam int CAP_CNT_W_MAX = 32;

  // Saturation value of the held-level width counter.
  localparam logic [15:0] WIDTH_SAT = 16'hFFFF;

  // Filter FSM states.
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } cap_state_t;

  // One transition event as seen by a monitor; count is sized for the
  // widest build and narrower instances use its low bits.
  typedef struct packed {
    logic                     rise;
    logic [CAP_CNT_W_MAX-1:0] count;
`ifdef LOGIC_MUX2_CAPTURE_WIDTH_EN
    logic [15:0]              width;
`endif
  } cap_evt_t;

  // Saturating increment for the held-level width counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == WIDTH_SAT) ? v : v + 16'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/logic_mux2_capture_if.sv
`default_nettype none
// ============================================================================
// Module   : logic_mux2_capture_if
// Purpose  : Valid/ready event bus carrying one transition record from the
//            capture block (master) to a monitor/scoreboard (slave).
// Options  : LOGIC_MUX2_CAPTURE_WIDTH_EN adds evt_width.
// Revision : 1.0 - initial release
// ============================================================================
interface logic_mux2_capture_if #(
  parameter int CNT_W = 8
);
  logic             evt_valid;
  logic             evt_ready;
  logic             evt_rise;
  logic [CNT_W-1:0] evt_count;
`ifdef LOGIC_MUX2_CAPTURE_WIDTH_EN
  logic [15:0]      evt_width;
`endif

  modport master (
    output evt_valid,
    output evt_rise,
    output evt_count,
`ifdef LOGIC_MUX2_CAPTURE_WIDTH_EN
    output evt_width,
`endif
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_rise,
    input  evt_count,
`ifdef LOGIC_MUX2_CAPTURE_WIDTH_EN
    input  evt_width,
`endif
    output evt_ready
  );
endinterface
`default_nettype wire

// File: rtl/logic_mux2_capture_sync_filter.sv
`default_nettype none
// ============================================================================
// Module   : mux2_sync_filter
// Purpose  : Synchronises the raw mux output into clk, then accepts a new
//            level only after it has differed from the filtered level for
//            STABLE_CYCLES consecutive enabled cycles. Emits a one-cycle
//            commit pulse (combinational, aligned with the filt_y update).
// Options  : none
// Revision : 1.0 - initial release
// ============================================================================
module mux2_sync_filter
  import logic_mux2_capture_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  wire  clk,
  input  wire  rst_n,
  input  wire  i_y,
  input  wire  i_en,
  output logic o_ys,
  output logic o_filt_y,
  output logic o_busy,
  output logic o_commit
);

  localparam int c_stab_w = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [c_stab_w-1:0] c_stab_last = c_stab_w'(STABLE_CYCLES - 1);
  localparam bit c_single = (STABLE_CYCLES == 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_ys;

  cap_state_t             r_state;
  cap_state_t             w_state_nxt;
  logic [c_stab_w-1:0]    r_stab_cnt;
  logic [c_stab_w-1:0]    w_stab_cnt_nxt;
  logic                   r_filt_y;
  logic                   w_filt_y_nxt;
  logic                   w_commit;

  // Shift the asynchronous input through the synchroniser chain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_y};
    end
  end

  assign w_ys = r_sync[SYNC_STAGES-1];

  // Register the filter state, stability count and accepted level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_stab_cnt <= '0;
      r_filt_y   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_stab_cnt <= w_stab_cnt_nxt;
      r_filt_y   <= w_filt_y_nxt;
    end
  end

  // Decide whether the synchronised level is a glitch or a real transition.
  always_comb begin
    w_state_nxt    = r_state;
    w_stab_cnt_nxt = r_stab_cnt;
    w_filt_y_nxt   = r_filt_y;
    w_commit       = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_en && (w_ys != r_filt_y)) begin
          if (c_single) begin
            // A single stable cycle is enough: accept on the spot.
            w_filt_y_nxt = w_ys;
            w_commit     = 1'b1;
          end else begin
            w_state_nxt    = SETTLE;
            w_stab_cnt_nxt = c_stab_w'(1);
          end
        end
      end
      SETTLE: begin
        if ((w_ys == r_filt_y) || !i_en) begin
          w_state_nxt    = IDLE;
          w_stab_cnt_nxt = '0;
        end else if (r_stab_cnt == c_stab_last) begin
          w_state_nxt    = IDLE;
          w_stab_cnt_nxt = '0;
          w_filt_y_nxt   = w_ys;
          w_commit       = 1'b1;
        end else begin
          w_stab_cnt_nxt = r_stab_cnt + c_stab_w'(1);
        end
      end
      default: begin
        w_state_nxt    = IDLE;
        w_stab_cnt_nxt = '0;
      end
    endcase
  end

  assign o_ys     = w_ys;
  assign o_filt_y = r_filt_y;
  assign o_busy   = (r_state == SETTLE);
  assign o_commit = w_commit;

endmodule
`default_nettype wire

// File: rtl/logic_mux2_capture.sv
`default_nettype none
// ============================================================================
// Module   : logic_mux2_capture
// Purpose  : Deglitched capture of the 2:1 mux output. Counts clean
//            transitions and offers each one as a record on a single-entry
//            valid/ready event register; a sticky flag marks dropped events.
// Options  : LOGIC_MUX2_CAPTURE_WIDTH_EN adds evt_width, the number of cycles
//            the previous level was held (saturating at 16'hFFFF).
// Revision : 1.0 - initial release
// ============================================================================
module logic_mux2_capture
  import logic_mux2_capture_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  wire                          clk,
  input  wire                          rst_n,
  input  wire                          i_y_in,
  input  wire                          i_en,
  output logic                         o_filt_y,
  output logic                         o_overflow,
  output logic                         o_busy,
  logic_mux2_capture_if.master         evt
);

  logic             w_ys;
  logic             w_filt_y;
  logic             w_busy;
  logic             w_commit;
  logic             w_handshake;
  logic             w_load;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic [CNT_W-1:0] r_cnt;
  logic             r_evt_valid;
  logic             r_evt_rise;
  logic [CNT_W-1:0] r_evt_count;
  logic             r_overflow;

  mux2_sync_filter #(
    .SYNC_STAGES   (SYNC_STAGES),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_filter (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_y      (i_y_in),
    .i_en     (i_en),
    .o_ys     (w_ys),
    .o_filt_y (w_filt_y),
    .o_busy   (w_busy),
    .o_commit (w_commit)
  );

  // The slot is free when empty or being drained in this same cycle.
  assign w_handshake = r_evt_valid && evt.evt_ready;
  assign w_load      = w_commit && (!r_evt_valid || evt.evt_ready);
  assign w_cnt_nxt   = r_cnt + CNT_W'(1);

  // Count transitions and manage the single-entry event register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_evt_valid <= 1'b0;
      r_evt_rise  <= 1'b0;
      r_evt_count <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_commit) begin
        // The count tracks every transition, even those that get dropped.
        r_cnt <= w_cnt_nxt;
      end
      if (w_load) begin
        r_evt_valid <= 1'b1;
        r_evt_rise  <= w_ys;
        r_evt_count <= w_cnt_nxt;
      end else if (w_commit) begin
        // Slot occupied and not draining: keep the held record, flag the loss.
        r_overflow <= 1'b1;
      end else if (w_handshake) begin
        r_evt_valid <= 1'b0;
      end
    end
  end

`ifdef LOGIC_MUX2_CAPTURE_WIDTH_EN
  logic [15:0] r_width_cnt;
  logic [15:0] r_evt_width;

  // Measure how long the filtered level has been held; restart on commit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_width_cnt <= 16'd1;
      r_evt_width <= 16'd0;
    end else begin
      if (w_commit) begin
        r_width_cnt <= 16'd1;
      end else begin
        r_width_cnt <= sat_inc16(r_width_cnt);
      end
      if (w_load) begin
        r_evt_width <= r_width_cnt;
      end
    end
  end

  assign evt.evt_width = r_evt_width;
`endif

  assign evt.evt_valid = r_evt_valid;
  assign evt.evt_rise  = r_evt_rise;
  assign evt.evt_count = r_evt_count;
  assign o_filt_y      = w_filt_y;
  assign o_overflow    = r_overflow;
  assign o_busy        = w_busy;

`ifndef SYNTHESIS
  // A change of the filtered level always leaves a record or a drop flag.
  a_filt_change_recorded : assert property (@(posedge clk)
    (rst_n && $past(rst_n) && (w_filt_y != $past(w_filt_y)))
      |-> (r_evt_valid || r_overflow));
`endif

endmodule
`default_nettype wire

// File: tb/tb_logic_mux2_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic_mux2_capture
// Purpose  : Self-checking bench for logic_mux2_capture: a directed vector
//            table, hand-written corner sequences and randomised stimulus,
//            all compared against a run-length reference model. A second
//            instance with CNT_W=2 shares the stimulus to check count wrap.
// Options  : LOGIC_MUX2_CAPTURE_WIDTH_EN also checks evt_width.
// Revision : 1.0 - initial release
// ============================================================================
module tb_logic_mux2_capture;

  localparam int SYNC = 2;
  localparam int STAB = 4;

  logic clk = 1'b0;
  logic rst_n, y_in, en, ready;
  logic filt1, ovf1, busy1, filt2, ovf2, busy2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  logic_mux2_capture_if #(.CNT_W(8)) evt1 ();
  logic_mux2_capture_if #(.CNT_W(2)) evt2 ();

  assign evt1.evt_ready = ready;
  assign evt2.evt_ready = ready;

  logic_mux2_capture #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(STAB), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_y_in(y_in), .i_en(en),
    .o_filt_y(filt1), .o_overflow(ovf1), .o_busy(busy1), .evt(evt1.master)
  );

  logic_mux2_capture #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(STAB), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .i_y_in(y_in), .i_en(en),
    .o_filt_y(filt2), .o_overflow(ovf2), .o_busy(busy2), .evt(evt2.master)
  );

  // ---------------- reference model ----------------
  // filt follows ys once ys has differed from it for STAB consecutive
  // enabled samples; events go to a one-slot mailbox.
  bit m_pipe [SYNC];
  bit m_filt, m_valid, m_rise, m_ovf;
  int m_run, m_cnt, m_count, m_wrun, m_width;

  task automatic model_step();
    bit ys, commit;
    if (!rst_n) begin
      for (int i = 0; i < SYNC; i++) m_pipe[i] = 1'b0;
      m_filt = 0; m_valid = 0; m_rise = 0; m_ovf = 0;
      m_run = 0; m_cnt = 0; m_count = 0; m_wrun = 1; m_width = 0;
      return;
    end
    ys = m_pipe[SYNC-1];
    commit = 1'b0;
    if (en && (ys != m_filt)) begin
      m_run++;
      if (m_run == STAB) begin
        commit = 1'b1;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    if (commit) begin
      m_cnt++;
      m_filt = ys;
      if (!m_valid || ready) begin
        m_valid = 1; m_rise = ys; m_count = m_cnt; m_width = m_wrun;
      end else begin
        m_ovf = 1;
      end
      m_wrun = 1;
    end else begin
      if (m_valid && ready) m_valid = 0;
      if (m_wrun < 65535) m_wrun++;
    end
    for (int i = SYNC - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
    m_pipe[0] = y_in;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("filt", int'(filt1), int'(m_filt));
    chk("busy", int'(busy1), int'(m_run != 0));
    chk("valid", int'(evt1.evt_valid), int'(m_valid));
    chk("overflow", int'(ovf1), int'(m_ovf));
    chk("filt_w2", int'(filt2), int'(m_filt));
    chk("valid_w2", int'(evt2.evt_valid), int'(m_valid));
    chk("overflow_w2", int'(ovf2), int'(m_ovf));
    chk("busy_w2", int'(busy2), int'(m_run != 0));
    if (m_valid) begin
      chk("rise", int'(evt1.evt_rise), int'(m_rise));
      chk("count", int'(evt1.evt_count), m_count % 256);
      chk("count_w2", int'(evt2.evt_count), m_count % 4);
`ifdef LOGIC_MUX2_CAPTURE_WIDTH_EN
      chk("width", int'(evt1.evt_width), m_width);
`endif
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic hold(input bit yv, input int n);
    y_in = yv;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit rst_n, y, en, ready;
    bit e_filt, e_valid, e_rise, e_busy, e_ovf;
    int e_count;
  } vec_t;

  vec_t vecs [9];
  int   busy_seen;
  int   exp_w2 [5];

  initial begin
    vecs[0] = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
    vecs[1] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
    vecs[2] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
    vecs[3] = '{1, 1, 1, 1, 0, 0, 0, 1, 0, 0};
    vecs[4] = '{1, 1, 1, 1, 0, 0, 0, 1, 0, 0};
    vecs[5] = '{1, 1, 1, 1, 0, 0, 0, 1, 0, 0};
    vecs[6] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 1};
    vecs[7] = '{1, 1, 1, 1, 1, 0, 1, 0, 0, 1};
    vecs[8] = '{1, 0, 1, 1, 1, 0, 0, 0, 0, 1};
    exp_w2  = '{1, 2, 3, 0, 1};

    rst_n = 1'b0; y_in = 1'b0; en = 1'b1; ready = 1'b1;
    @(negedge clk);

    // Clean rise with latency, then drain on the following cycle.
    for (int i = 0; i < 9; i++) begin
      rst_n = vecs[i].rst_n; y_in = vecs[i].y; en = vecs[i].en; ready = vecs[i].ready;
      tick();
      chk($sformatf("vec%0d_filt", i), int'(filt1), int'(vecs[i].e_filt));
      chk($sformatf("vec%0d_valid", i), int'(evt1.evt_valid), int'(vecs[i].e_valid));
      chk($sformatf("vec%0d_busy", i), int'(busy1), int'(vecs[i].e_busy));
      chk($sformatf("vec%0d_ovf", i), int'(ovf1), int'(vecs[i].e_ovf));
      if (vecs[i].e_valid) begin
        chk($sformatf("vec%0d_rise", i), int'(evt1.evt_rise), int'(vecs[i].e_rise));
        chk($sformatf("vec%0d_count", i), int'(evt1.evt_count), vecs[i].e_count);
      end
    end

    // Glitch shorter than the stability window: no commit, no event.
    do_reset(); hold(0, 4);
    busy_seen = 0;
    y_in = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); busy_seen += int'(busy1); end
    y_in = 1'b0;
    for (int i = 0; i < 8; i++) begin tick(); busy_seen += int'(busy1); end
    chk("glitch_filt", int'(filt1), 0);
    chk("glitch_valid", int'(evt1.evt_valid), 0);
    chk("glitch_busy_seen", int'(busy_seen > 0), 1);

    // Three toggles with the consumer stalled: first record held, rest dropped.
    do_reset(); ready = 1'b0; hold(0, 4);
    hold(1, 8); hold(0, 8); hold(1, 8);
    chk("ovf_flag", int'(ovf1), 1);
    chk("ovf_held_rise", int'(evt1.evt_rise), 1);
    chk("ovf_held_count", int'(evt1.evt_count), 1);
    ready = 1'b1; tick();
    chk("ovf_drained", int'(evt1.evt_valid), 0);
    chk("ovf_sticky", int'(ovf1), 1);

    // New event lands in the same cycle as the handshake of the held one.
    do_reset(); ready = 1'b0; hold(0, 4); hold(1, 8);
    y_in = 1'b0;
    for (int i = 0; i < 5; i++) begin tick(); chk("hs_valid_hold", int'(evt1.evt_valid), 1); end
    ready = 1'b1; tick();
    chk("hs_valid", int'(evt1.evt_valid), 1);
    chk("hs_count", int'(evt1.evt_count), 2);
    chk("hs_rise", int'(evt1.evt_rise), 0);
    chk("hs_ovf", int'(ovf1), 0);

    // Reset while settling with an event pending clears everything.
    do_reset(); ready = 1'b0; hold(0, 4); hold(1, 8); hold(0, 3);
    chk("rst_pre_busy", int'(busy1), 1);
    do_reset();
    chk("rst_filt", int'(filt1), 0);
    chk("rst_valid", int'(evt1.evt_valid), 0);
    chk("rst_busy", int'(busy1), 0);
    chk("rst_ovf", int'(ovf1), 0);
    chk("rst_count", int'(evt1.evt_count), 0);

    // Count wrap on the CNT_W=2 instance.
    do_reset(); ready = 1'b1; hold(0, 20);
    for (int k = 0; k < 5; k++) begin
      hold(~y_in, 6);
      chk($sformatf("wrap%0d_w2", k), int'(evt2.evt_count), exp_w2[k]);
      chk($sformatf("wrap%0d_w8", k), int'(evt1.evt_count), k + 1);
      hold(y_in, 2);
    end

    // Randomised traffic including en drops, stalls and occasional reset.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 4) == 0) y_in = ~y_in;
      en    = ($urandom_range(0, 9) != 0);
      ready = ($urandom_range(0, 2) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
